// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART TX arbiter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK  = 2'd1,
        DRAIN = 2'd2
    } arb_state_e;

    // Index width for a requester vector, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module uart_rr_picker
    import uart_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDXW = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDXW-1:0] idx,
    output logic            any
);

    int unsigned cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = (32'(ptr) + k) % NREQ;
            if (!any && req[cand]) begin
                any         = 1'b1;
                idx         = IDXW'(cand);
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX byte channel between NREQ packet sources.
// Optional grant watchdog enabled by defining UART_ARB_WATCHDOG_EN.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NREQ           = 4,
    parameter int unsigned BYTESIZES      = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50_000
) (
    input  logic                      clock,
    input  logic                      nreset,
    input  logic [NREQ-1:0]           req_valid_in,
    input  logic [NREQ*BYTESIZES-1:0] req_data_in,
    input  logic [NREQ-1:0]           req_last_in,
    output logic [NREQ-1:0]           req_ready_out,
    output logic [NREQ-1:0]           grant_out,
    output logic                      tx_valid_out,
    output logic [BYTESIZES-1:0]      tx_data_out,
    input  logic                      tx_ready_in,
    output logic                      timeout_out
);

    localparam int unsigned IDXW = idx_width(NREQ);

    localparam logic [1:0] ST_IDLE  = 2'(IDLE);
    localparam logic [1:0] ST_LOCK  = 2'(LOCK);
    localparam logic [1:0] ST_DRAIN = 2'(DRAIN);

    if (NREQ < 2 || NREQ > 8 || BYTESIZES == 0 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("uart_tx_arbiter: parameter out of range");
    end

    logic [1:0]           state, state_nx;
    logic [IDXW-1:0]      ptr, ptr_nx;
    logic [IDXW-1:0]      g_idx, g_idx_nx;
    logic [NREQ-1:0]      grant_nx;
    logic                 tx_valid_nx;
    logic [BYTESIZES-1:0] tx_data_nx;

    logic [NREQ-1:0]      pick_grant;
    logic [IDXW-1:0]      pick_idx;
    logic                 pick_any;

    logic                 slot_free_c;
    logic                 accept_c;
    logic                 last_c;
    logic                 timeout_c;
    logic [BYTESIZES-1:0] lane_data_c;

    uart_rr_picker #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_picker (
        .req   (req_valid_in),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // The TX slot can take a byte when empty or being emptied this cycle.
    assign slot_free_c = !tx_valid_out || tx_ready_in;
    assign accept_c    = (state == ST_LOCK) && req_valid_in[g_idx] && slot_free_c;
    assign last_c      = req_last_in[g_idx];

    always_comb begin
        lane_data_c = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (g_idx == IDXW'(i)) begin
                lane_data_c = req_data_in[i*BYTESIZES +: BYTESIZES];
            end
        end
    end

    always_comb begin
        req_ready_out = '0;
        if (state == ST_LOCK) begin
            req_ready_out = grant_out & {NREQ{slot_free_c}};
        end
    end

`ifdef UART_ARB_WATCHDOG_EN
    logic [31:0] wd_cnt;

    // Fires on the idle cycle that brings the count to TIMEOUT_CYCLES-1.
    assign timeout_c = (state == ST_LOCK) && !accept_c
                       && ((wd_cnt + 32'd1) == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            wd_cnt      <= '0;
            timeout_out <= 1'b0;
        end else begin
            timeout_out <= timeout_c;
            if (state != ST_LOCK || accept_c || timeout_c) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + 32'd1;
            end
        end
    end
`else
    assign timeout_c   = 1'b0;
    assign timeout_out = 1'b0;
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_nx    = state;
        grant_nx    = grant_out;
        ptr_nx      = ptr;
        g_idx_nx    = g_idx;
        tx_valid_nx = tx_valid_out;
        tx_data_nx  = tx_data_out;

        if (accept_c) begin
            tx_valid_nx = 1'b1;
            tx_data_nx  = lane_data_c;
        end else if (tx_ready_in) begin
            tx_valid_nx = 1'b0;
        end

        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_nx = pick_grant;
                    g_idx_nx = pick_idx;
                    state_nx = ST_LOCK;
                end
            end
            ST_LOCK: begin
                if ((accept_c && last_c) || timeout_c) begin
                    state_nx = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!tx_valid_out) begin
                    grant_nx = '0;
                    ptr_nx   = (g_idx == IDXW'(NREQ - 1)) ? '0 : g_idx + IDXW'(1);
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                grant_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state        <= ST_IDLE;
            ptr          <= '0;
            g_idx        <= '0;
            grant_out    <= '0;
            tx_valid_out <= 1'b0;
            tx_data_out  <= '0;
        end else begin
            state        <= state_nx;
            ptr          <= ptr_nx;
            g_idx        <= g_idx_nx;
            grant_out    <= grant_nx;
            tx_valid_out <= tx_valid_nx;
            tx_data_out  <= tx_data_nx;
        end
    end

endmodule
